// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer and the Control unit:
// sequencer state encoding and the RV32I major opcodes Control decodes.
package hazard_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall and flush performance counters: two independently enabled CNT_W-bit
// counters that wrap naturally and share one synchronous clear.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             stall_en,
  input  logic             flush_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (clear) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_en) stall_cnt <= stall_cnt + 1'b1;
      if (flush_en) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer beside ID: load-use bubbles, whole-pipe freeze during
// slow data-memory accesses with timeout abort, and IF/ID flush on taken branches.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             EX_MemRead_i,
  input  logic             branch_inst_i,
  input  logic             branch_taken_i,
  input  logic             mem_valid_i,
  input  logic             dmem_ack_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             noop_o,
  output logic             flush_o,
  output logic             pipe_stall_o,
  output logic             dmem_req_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Last counter value at which a further unacknowledged cycle still fits the budget.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [TMO_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             err_q, err_nxt;
  logic             lu;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err_q;

    lu = EX_MemRead_i && (EX_rd_i != 5'd0) &&
         ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));

    dmem_req_o   = (state == ST_MEM_WAIT) || mem_valid_i;
    pipe_stall_o = dmem_req_o && !dmem_ack_i;

    unique case (state)
      ST_RUN: begin
        if (mem_valid_i && !dmem_ack_i) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = TMO_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_nxt = ST_RUN;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
          if (wait_cnt >= TMO_LAST) begin
            state_nxt = ST_RUN;
            err_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    noop_o      = 1'b0;
    flush_o     = branch_inst_i && branch_taken_i;
    if (!rst_i) begin
      // Hold fetch and feed bubbles while reset is asserted; abandon any access.
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      noop_o       = 1'b1;
      flush_o      = 1'b0;
      dmem_req_o   = 1'b0;
      pipe_stall_o = 1'b0;
    end else if (pipe_stall_o) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      flush_o     = 1'b0;
    end else if (lu) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      noop_o      = 1'b1;
      flush_o     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  assign err_o = err_q;

  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk      (clk_i),
    .clear    (!rst_i),
    .stall_en (noop_o || pipe_stall_o),
    .flush_en (flush_o),
    .stall_cnt(stall_cnt_o),
    .flush_cnt(flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// random traffic, checked against a cycle-level behavioural model of the sequencer.
module tb_pipeline_hazard_ctrl;

  localparam int TMO   = 5;
  localparam int TMO_W = 4;
  localparam int CNT_W = 6;
  localparam int CMASK = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1, rs2, rd;
  logic             mem_read, br_inst, br_taken, mem_valid, ack;
  logic             pc_write, ifid_write, noop, flush, pipe_stall, dmem_req, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(TMO),
    .TMO_W      (TMO_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ID_rs1_i      (rs1),
    .ID_rs2_i      (rs2),
    .EX_rd_i       (rd),
    .EX_MemRead_i  (mem_read),
    .branch_inst_i (br_inst),
    .branch_taken_i(br_taken),
    .mem_valid_i   (mem_valid),
    .dmem_ack_i    (ack),
    .PCWrite_o     (pc_write),
    .IFIDWrite_o   (ifid_write),
    .noop_o        (noop),
    .flush_o       (flush),
    .pipe_stall_o  (pipe_stall),
    .dmem_req_o    (dmem_req),
    .err_o         (err),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit pc, ifid, noop, flush, stall, req, err;
    int scnt, fcnt;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model state: memory access in progress, cycles waited so far, sticky error.
  bit m_wait = 0;
  int m_waited = 0;
  bit m_err = 0;
  int m_scnt = 0;
  int m_fcnt = 0;

  task automatic check(input string name, input longint act, input longint req, input int cyc);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
  task automatic step(input bit r, input int s1, input int s2, input int d, input bit mr,
                      input bit bi, input bit bt, input bit mv, input bit ak);
    exp_t e;
    bit   hazard;
    @(posedge clk);
    #1;
    cycle++;
    rst = r; rs1 = 5'(s1); rs2 = 5'(s2); rd = 5'(d); mem_read = mr;
    br_inst = bi; br_taken = bt; mem_valid = mv; ack = ak;

    hazard = mr && d != 0 && (d == s1 || d == s2);
    e.cyc  = cycle;
    e.err  = m_err;
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    e.req  = r && (m_wait || mv);
    e.stall = e.req && !ak;
    if (!r) begin
      e.pc = 0; e.ifid = 0; e.noop = 1; e.flush = 0;
    end else if (e.stall) begin
      e.pc = 0; e.ifid = 0; e.noop = 0; e.flush = 0;
    end else if (hazard) begin
      e.pc = 0; e.ifid = 0; e.noop = 1; e.flush = 0;
    end else begin
      e.pc = 1; e.ifid = 1; e.noop = 0; e.flush = bi && bt;
    end
    q.push_back(e);

    if (!r) begin
      m_wait = 0; m_waited = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e.noop || e.stall) m_scnt = (m_scnt + 1) & CMASK;
      if (e.flush) m_fcnt = (m_fcnt + 1) & CMASK;
      if (!m_wait) begin
        if (mv && !ak) begin
          m_wait = 1;
          m_waited = 1;
        end
      end else if (ak) begin
        m_wait = 0;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_wait = 0;
          m_err = 1;
        end
      end
    end
  endtask

  task automatic idle(input bit r);
    step(r, 1, 2, 3, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc_write",   pc_write,   e.pc,    e.cyc);
        check("ifid_write", ifid_write, e.ifid,  e.cyc);
        check("noop",       noop,       e.noop,  e.cyc);
        check("flush",      flush,      e.flush, e.cyc);
        check("pipe_stall", pipe_stall, e.stall, e.cyc);
        check("dmem_req",   dmem_req,   e.req,   e.cyc);
        check("err",        err,        e.err,   e.cyc);
        check("stall_cnt",  stall_cnt,  e.scnt,  e.cyc);
        check("flush_cnt",  flush_cnt,  e.fcnt,  e.cyc);
      end
    end
  end

  initial begin
    rst = 0; rs1 = 0; rs2 = 0; rd = 0; mem_read = 0;
    br_inst = 0; br_taken = 0; mem_valid = 0; ack = 0;
    @(posedge clk);

    idle(0);
    idle(1);
    // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then proceed
    step(1, 5, 1, 5, 1, 0, 0, 0, 0);
    idle(1);
    // rd = x0 never triggers a hazard
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    // access acknowledged after three wait cycles
    for (int i = 0; i < 3; i++) step(1, 1, 2, 3, 0, 0, 0, 1, 0);
    step(1, 1, 2, 3, 0, 0, 0, 1, 1);
    idle(1);
    // zero-wait access
    step(1, 1, 2, 3, 0, 0, 0, 1, 1);
    // never acknowledged: abort after TMO wait cycles, err sticky
    for (int i = 0; i < TMO + 2; i++) step(1, 1, 2, 3, 0, 0, 0, i < TMO, 0);
    // taken branch behind a load-use: suppressed, then flushed
    step(1, 7, 0, 7, 1, 1, 1, 0, 0);
    step(1, 7, 0, 0, 0, 1, 1, 0, 0);
    // reset in the middle of a memory wait
    for (int i = 0; i < 2; i++) step(1, 1, 2, 3, 0, 0, 0, 1, 0);
    step(0, 1, 2, 3, 0, 0, 0, 1, 0);
    idle(1);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(511) != 0,
           $urandom_range(3), $urandom_range(3), $urandom_range(3),
           $urandom_range(1), $urandom_range(9) < 3, $urandom_range(1),
           $urandom_range(9) < 3, $urandom_range(9) < 3);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0, cycle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
